// File: rtl/proximity_beeper.sv
// Proximity beeper: maps a measured distance to silent, intermittent or continuous buzzer drive.
// Optional mute feature enabled by defining BEEPER_MUTE_EN.
module proximity_beeper #(
    parameter int DIST_W     = 8,
    parameter int NUM_ZONES  = 4,
    parameter int CONT_DIST  = 1,
    parameter int TICK_DIV   = 50000,
    parameter int BASE_TICKS = 50,
    parameter int MUTE_TICKS = 3000,
    localparam int ZONE_W    = $clog2(NUM_ZONES + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIST_W-1:0] distance,
    input  logic              mute_req,
    output logic              alarm,
    output logic [ZONE_W-1:0] zone,
    output logic              mute_active
);

    localparam int HP_MAX = BASE_TICKS << (NUM_ZONES - 1);
    localparam int PH_W   = ($clog2(HP_MAX) < 1) ? 1 : $clog2(HP_MAX);
    localparam int PRE_W  = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
    localparam logic [ZONE_W-1:0] Z_CONT   = ZONE_W'(NUM_ZONES);
    localparam logic [ZONE_W-1:0] Z_SILENT = ZONE_W'(NUM_ZONES + 1);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_SILENT = 2'd0,
        S_ON     = 2'd1,
        S_OFF    = 2'd2,
        S_CONT   = 2'd3
    } state_t;

    logic [DIST_W-1:0] dist_q;
    logic              dist_vld;
    logic [PRE_W-1:0]  presc;
    logic              tick;
    logic [ZONE_W-1:0] zone_q;
    logic [ZONE_W-1:0] zone_dec;
    logic              zone_change;
    logic [PH_W-1:0]   phase_cnt;
    logic [PH_W-1:0]   phase_next;
    logic [PH_W-1:0]   hp_last;
    logic [31:0]       dist_ext;
    logic [31:0]       dist_off;
    logic              mute_next;
    logic              alarm_next;
    state_t            state;
    state_t            state_next;

    // dist_vld keeps the reset value of dist_q from being decoded as a zone change.
    always_ff @(posedge clk) begin
        if (rst) begin
            dist_q   <= '0;
            dist_vld <= 1'b0;
        end else begin
            dist_q   <= distance;
            dist_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || presc == PRE_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (presc == PRE_LAST);

    always_comb begin
        dist_ext = 32'(dist_q);
        dist_off = dist_ext - 32'(CONT_DIST) - 32'd1;
        zone_dec = Z_SILENT;
        if (dist_ext <= 32'(CONT_DIST)) begin
            zone_dec = Z_CONT;
        end else if (dist_off < 32'(NUM_ZONES)) begin
            zone_dec = ZONE_W'(dist_off);
        end
    end

    assign zone_change = dist_vld && (zone_dec != zone_q);
    assign hp_last     = PH_W'((BASE_TICKS << zone_q) - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_SILENT;
            phase_cnt <= '0;
            zone_q    <= Z_SILENT;
            alarm     <= 1'b0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_next;
            zone_q    <= zone_change ? zone_dec : zone_q;
            alarm     <= alarm_next;
        end
    end

    // A zone change wins over a phase expiry landing on the same cycle.
    always_comb begin
        state_next = state;
        phase_next = phase_cnt;
        if (zone_change) begin
            phase_next = '0;
            if (zone_dec == Z_CONT) begin
                state_next = S_CONT;
            end else if (zone_dec == Z_SILENT) begin
                state_next = S_SILENT;
            end else begin
                state_next = S_ON;
            end
        end else if ((state == S_ON || state == S_OFF) && tick) begin
            if (phase_cnt == hp_last) begin
                phase_next = '0;
                state_next = (state == S_ON) ? S_OFF : S_ON;
            end else begin
                phase_next = phase_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        alarm_next = (state_next == S_ON || state_next == S_CONT) && !mute_next;
    end

    assign zone = zone_q;

`ifdef BEEPER_MUTE_EN
    localparam int MC_W = ($clog2(MUTE_TICKS + 1) < 1) ? 1 : $clog2(MUTE_TICKS + 1);

    logic [MC_W-1:0] mute_cnt;
    logic [MC_W-1:0] mute_cnt_next;

    // Approaching the obstacle (lower code or continuous) cancels a mute early.
    always_comb begin
        mute_next     = mute_active;
        mute_cnt_next = mute_cnt;
        if (zone_change && (zone_dec < zone_q || zone_dec == Z_CONT)) begin
            mute_next     = 1'b0;
            mute_cnt_next = '0;
        end else if (mute_req && (state == S_ON || state == S_OFF)) begin
            mute_next     = 1'b1;
            mute_cnt_next = MC_W'(MUTE_TICKS);
        end else if (mute_active && tick) begin
            if (mute_cnt <= MC_W'(1)) begin
                mute_next     = 1'b0;
                mute_cnt_next = '0;
            end else begin
                mute_cnt_next = mute_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mute_active <= 1'b0;
            mute_cnt    <= '0;
        end else begin
            mute_active <= mute_next;
            mute_cnt    <= mute_cnt_next;
        end
    end
`else
    logic unused_mute;

    assign unused_mute = mute_req | (MUTE_TICKS == 0);
    assign mute_next   = 1'b0;
    assign mute_active = 1'b0;
`endif

endmodule
